// File: rtl/comparador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : comparador_serial
//  Description : Bit-serial magnitude comparator. One bit pair of the captured
//                operands is resolved per clock, MSB first, with a sticky
//                greater/less propagation rule. Signed (two's complement) or
//                unsigned mode is selected per operation.
//                Handshake: start is accepted only when not busy; busy is high
//                during evaluation; done pulses for one cycle when g/l/e are
//                updated. Results hold until the next done.
//  Parameters  : SIZE - operand width in bits (SIZE >= 1)
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous reset, active-high
//                start - operation request (ignored while busy)
//                a, b  - operands, captured on the accepting edge
//                sgn   - 1 = signed compare, 0 = unsigned (captured with a/b)
//                busy  - high while evaluating
//                done  - one-cycle pulse, results valid from this cycle
//                g/l/e - A > B / A < B / A == B
//  Options     : COMP_EARLY_EXIT_EN - when defined, evaluation stops on the
//                first differing bit instead of always running SIZE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparador_serial #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            sgn,
    output logic            busy,
    output logic            done,
    output logic            g,
    output logic            l,
    output logic            e
);

    localparam int c_cnt_w = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [SIZE-1:0]      r_a;
    logic [SIZE-1:0]      r_b;
    logic                 r_sgn;
    logic                 r_gp;
    logic                 r_lp;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_g;
    logic                 r_l;
    logic                 r_e;

    logic w_msb;
    logic w_abit;
    logic w_bbit;
    logic w_ai;
    logic w_bi;
    logic w_gp_next;
    logic w_lp_next;
    logic w_last;

    assign w_msb  = (r_cnt == c_cnt_init);
    assign w_abit = r_a[r_cnt];
    assign w_bbit = r_b[r_cnt];

    // In signed mode a set sign bit means the smaller value, which is the
    // unsigned rule with the operand bits exchanged.
    assign w_ai = (r_sgn && w_msb) ? w_bbit : w_abit;
    assign w_bi = (r_sgn && w_msb) ? w_abit : w_bbit;

    // Partials are sticky: once one side wins, the other can never be set.
    assign w_gp_next = r_gp | (~r_lp & w_ai & ~w_bi);
    assign w_lp_next = r_lp | (~r_gp & ~w_ai & w_bi);

`ifdef COMP_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) | w_gp_next | w_lp_next;
`else
    assign w_last = (r_cnt == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_gp    <= 1'b0;
            r_lp    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sgn   <= sgn;
                        r_gp    <= 1'b0;
                        r_lp    <= 1'b0;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_gp  <= w_gp_next;
                    r_lp  <= w_lp_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_g     <= w_gp_next;
                        r_l     <= w_lp_next;
                        r_e     <= ~w_gp_next & ~w_lp_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sgn   <= sgn;
                        r_gp    <= 1'b0;
                        r_lp    <= 1'b0;
                        r_cnt   <= c_cnt_init;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign g    = r_g;
    assign l    = r_l;
    assign e    = r_e;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparador_serial
//  Description : Self-checking bench for comparador_serial (SIZE = 8).
//                Expected results and latencies come from a behavioural model
//                and are queued when an operation is started, then popped
//                when done is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparador_serial;

    localparam int SIZE = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            sgn;
    logic            busy;
    logic            done;
    logic            g;
    logic            l;
    logic            e;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       g;
        logic       l;
        logic       e;
        int         lat;
        string      name;
    } exp_t;

    exp_t sb[$];

    comparador_serial #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sgn   (sgn),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .l     (l),
        .e     (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result from integer compare, latency counted in edges
    // from the capture edge up to the edge that raises done.
    function automatic exp_t model(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                                   input logic sv, input string nm);
        exp_t x;
        int   k;
        bit   found;
        if (sv) begin
            x.g = ($signed(av) > $signed(bv));
            x.l = ($signed(av) < $signed(bv));
        end else begin
            x.g = (av > bv);
            x.l = (av < bv);
        end
        x.e = (av == bv);
        k = SIZE;
`ifdef COMP_EARLY_EXIT_EN
        found = 1'b0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (!found && (av[i] != bv[i])) begin
                k = SIZE - i;
                found = 1'b1;
            end
        end
`else
        found = 1'b0;
`endif
        x.lat = 1 + k;
        x.name = nm;
        return x;
    endfunction

    // Advances whole clock cycles until done is seen or the budget runs out.
    task automatic wait_done(inout int edges, output bit timeout);
        while (!done && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
        timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, g, l, e} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy,done,g,l,e=%b required 00000", {busy, done, g, l, e});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete operation from idle: start, result, latency, done pulse.
    task automatic test_op(input string nm, input logic [SIZE-1:0] av,
                           input logic [SIZE-1:0] bv, input logic sv);
        exp_t x;
        int   edges;
        bit   to;
        @(negedge clk);
        a = av; b = bv; sgn = sv; start = 1'b1;
        sb.push_back(model(av, bv, sv, nm));
        @(posedge clk);
        #1;
        edges = 1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy: got %b required 1", nm, busy);
        end
        wait_done(edges, to);
        x = sb.pop_front();
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d edges required done", nm, edges);
        end else begin
            n_cmp++;
            if (edges !== x.lat) begin
                n_err++;
                $display("FAIL %s_latency: got %0d edges required %0d", nm, edges, x.lat);
            end
            n_cmp++;
            if ({g, l, e, busy} !== {x.g, x.l, x.e, 1'b0}) begin
                n_err++;
                $display("FAIL %s_result: got g,l,e,busy=%b required %b", nm, {g, l, e, busy},
                         {x.g, x.l, x.e, 1'b0});
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({done, g, l, e} !== {1'b0, x.g, x.l, x.e}) begin
                n_err++;
                $display("FAIL %s_pulse_hold: got done,g,l,e=%b required %b", nm, {done, g, l, e},
                         {1'b0, x.g, x.l, x.e});
            end
        end
    endtask

    task automatic test_unsigned();
        test_op("unsigned_80_7f", 8'h80, 8'h7F, 1'b0);
    endtask

    task automatic test_signed();
        test_op("signed_80_7f", 8'h80, 8'h7F, 1'b1);
    endtask

    task automatic test_equal();
        test_op("equal_u", 8'h5A, 8'h5A, 1'b0);
        test_op("equal_s", 8'h5A, 8'h5A, 1'b1);
    endtask

    task automatic test_early_exit();
        test_op("exit_80_00", 8'h80, 8'h00, 1'b0);
        test_op("lsb_diff", 8'h00, 8'h01, 1'b0);
    endtask

    task automatic test_random();
        logic [SIZE-1:0] av;
        logic [SIZE-1:0] bv;
        logic            sv;
        for (int i = 0; i < 8; i++) begin
            av = SIZE'($urandom);
            bv = (i % 3 == 0) ? av ^ SIZE'(1 << $urandom_range(0, SIZE - 1)) : SIZE'($urandom);
            sv = 1'($urandom);
            test_op($sformatf("rand%0d", i), av, bv, sv);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int   edges;
        bit   to;
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; sgn = 1'b0; start = 1'b1;
        sb.push_back(model(8'h5A, 8'h5A, 1'b0, "b2b_first"));
        @(posedge clk);
        #1;
        edges = 1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            edges++;
        end
        // Request while busy: must be ignored.
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        wait_done(edges, to);
        x = sb.pop_front();
        n_cmp++;
        if (to || edges !== x.lat || {g, l, e} !== {x.g, x.l, x.e}) begin
            n_err++;
            $display("FAIL b2b_first: got timeout=%b edges=%0d g,l,e=%b required edges=%0d g,l,e=%b",
                     to, edges, {g, l, e}, x.lat, {x.g, x.l, x.e});
        end
        // Start held in the done cycle: accepted straight away.
        a = 8'h01; b = 8'h02; sgn = 1'b0; start = 1'b1;
        sb.push_back(model(8'h01, 8'h02, 1'b0, "b2b_second"));
        @(posedge clk);
        #1;
        edges = 1;
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_accept: got busy,done=%b required 10", {busy, done});
        end
        wait_done(edges, to);
        x = sb.pop_front();
        n_cmp++;
        if (to || edges !== x.lat || {g, l, e} !== {x.g, x.l, x.e}) begin
            n_err++;
            $display("FAIL b2b_second: got timeout=%b edges=%0d g,l,e=%b required edges=%0d g,l,e=%b",
                     to, edges, {g, l, e}, x.lat, {x.g, x.l, x.e});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_run_reset();
        bit seen;
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, g, l, e} !== 5'b0) begin
            n_err++;
            $display("FAIL midrun_reset: got busy,done,g,l,e=%b required 00000", {busy, done, g, l, e});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL midrun_no_done: got activity after abort=%b required 0", seen);
        end
        test_op("after_reset", 8'h01, 8'h02, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_equal();
        test_early_exit();
        test_random();
        test_back_to_back();
        test_mid_run_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
